instr_loader: RTL and testbench

Boot-time program loader that writes instruction memory through its debug write port: `dbg_wr_en`, `dbg_addr`, `dbg_instr`. It receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one debug write per word. It holds the CPU in reset until the frame is loaded and its checksum verifies. It sits between the host link (UART receiver / testbench byte source) and the instruction memory's debug write port.

---
 rtl/instr_loader.sv | 169 ++++++++++++++++
 tb/tb_instr_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time program loader: turns a framed little-endian byte stream into instruction words,
// writes them through the imem debug port and holds the CPU in reset until the checksum verifies.
module instr_loader #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int unsigned     MAX_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_req,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            error
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWrite,
        StCsum,
        StDone,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     idx_q, idx_d;
    logic [31:0]     word_q, word_d;
    logic [7:0]      xor_q, xor_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;

    logic            accept;
    logic [31:0]     hdr_full;
    logic [31:0]     word_full;

    assign accept    = in_valid & in_ready;
    // Bytes shift in from the top so the first byte lands in [7:0] after four accepts.
    assign hdr_full  = {in_data, cnt_q[31:8]};
    assign word_full = {in_data, word_q[31:8]};

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        xor_d   = xor_q;
        addr_d  = addr_q;
        instr_d = instr_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (load_req) begin
                    state_d = StHdr;
                    bcnt_d  = 2'd0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end
            StHdr: begin
                if (accept) begin
                    cnt_d  = hdr_full;
                    xor_d  = xor_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (hdr_full > MAX_WORDS) begin
                            state_d = StError;
                        end else if (hdr_full == '0) begin
                            state_d = StCsum;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d = word_full;
                    xor_d  = xor_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = StWrite;
                        // Latched here so address/data hold after the strobe drops.
                        addr_d  = BASE_ADDR + (XLEN'(idx_q) << 2);
                        instr_d = XLEN'(word_full);
                    end
                end
            end
            StWrite: begin
                idx_d = idx_q + 32'd1;
                if (idx_q + 32'd1 == cnt_q) begin
                    state_d = StCsum;
                end else begin
                    state_d = StData;
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        dbg_wr_en = 1'b0;
        busy      = 1'b0;
        cpu_hold  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state_q)
            StHdr, StData, StCsum: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            StWrite: begin
                dbg_wr_en = 1'b1;
                busy      = 1'b1;
                cpu_hold  = 1'b1;
            end
            StDone: done = 1'b1;
            StError: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_addr  = addr_q;
    assign dbg_instr = instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bcnt_q  <= 2'd0;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            xor_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            xor_q   <= xor_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, hand-written timing corners and
// randomized frames checked against a frame-level model of expected writes and status.
module tb_instr_loader;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] BASE      = 32'h0;
    localparam int unsigned MAX_WORDS = 256;

    logic            clk = 1'b0;
    logic            rst, load_req, in_valid;
    logic [7:0]      in_data;
    logic            in_ready, dbg_wr_en, cpu_hold, busy, done, error;
    logic [XLEN-1:0] dbg_addr, dbg_instr;

    instr_loader #(
        .XLEN      (XLEN),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dbg_wr_en (dbg_wr_en),
        .dbg_addr  (dbg_addr),
        .dbg_instr (dbg_instr),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] cur_w[$];
    logic [7:0]  bq[$];

    typedef struct {
        int unsigned n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          cs_mode;   // 0 correct, 1 fixed value, 2 correct ^ value
        logic [7:0]  cs_val;
        int          gap;       // idle cycles after each byte; negative means random 0..2
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Capture every write strobe mid-cycle; input must be stalled while writing.
    always @(negedge clk) begin
        if (dbg_wr_en === 1'b1) begin
            wa_q.push_back(dbg_addr);
            wd_q.push_back(dbg_instr);
            check("ready_low_in_write", {31'b0, in_ready}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        int g;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, required accept within 50 cycles",
                     b);
        end
        g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load();
        wa_q.delete();
        wd_q.delete();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Header plus (if the count is acceptable) data bytes; returns their XOR.
    task automatic build_frame(input int unsigned n, output logic [7:0] x);
        logic [31:0] nv;
        logic [31:0] w;
        nv = n;
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(nv[8*i +: 8]);
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < int'(n); i++) begin
                w = cur_w[i];
                for (int j = 0; j < 4; j++) bq.push_back(w[8*j +: 8]);
            end
        end
        x = 8'h00;
        foreach (bq[i]) x ^= bq[i];
    endtask

    task automatic run_frame(input int unsigned n, input int cs_mode, input logic [7:0] cs_val,
                             input int gap, input bit exp_done, input bit exp_err,
                             input string tag);
        logic [7:0] x, cs;
        int         nw;
        build_frame(n, x);
        cs = (cs_mode == 1) ? cs_val : (cs_mode == 2) ? (x ^ cs_val) : x;
        pulse_load();
        foreach (bq[i]) send_byte(bq[i], gap);
        if (n <= MAX_WORDS) begin
            check({tag, "_pre_done"}, {31'b0, done}, 32'd0);
            check({tag, "_pre_hold"}, {31'b0, cpu_hold}, 32'd1);
            send_byte(cs, 0);
        end
        check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
        check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
        check({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, !exp_done});
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
        nw = (n <= MAX_WORDS) ? int'(n) : 0;
        check({tag, "_wr_count"}, wa_q.size(), nw);
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa_q[i], BASE + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wd_q[i], cur_w[i]);
        end
        if (nw > 0) begin
            check({tag, "_addr_hold"}, dbg_addr, BASE + 32'(4 * (nw - 1)));
            check({tag, "_data_hold"}, dbg_instr, cur_w[nw-1]);
        end
    endtask

    task automatic fill_words(input int unsigned n, input logic [31:0] w0, input logic [31:0] w1);
        cur_w.delete();
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < int'(n); i++)
                cur_w.push_back(i == 0 ? w0 : i == 1 ? w1 : $urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        vecs[0] = '{2, 32'h00000013, 32'h00A00093, 0, 8'h00, 0, 1'b1, 1'b0};
        vecs[1] = '{2, 32'h00000013, 32'h00A00093, 1, 8'h39, 0, 1'b0, 1'b1};
        vecs[2] = '{0, 32'h0, 32'h0, 0, 8'h00, 0, 1'b1, 1'b0};
        vecs[3] = '{MAX_WORDS + 1, 32'h0, 32'h0, 0, 8'h00, 0, 1'b0, 1'b1};
        vecs[4] = '{3, 32'h12345678, 32'h9ABCDEF0, 0, 8'h00, 1, 1'b1, 1'b0};
        vecs[5] = '{MAX_WORDS, 32'hFFFFFFFF, 32'h80000001, 0, 8'h00, 0, 1'b1, 1'b0};
        vecs[6] = '{5, 32'hCAFEF00D, 32'h0BADBEEF, 2, 8'h80, -1, 1'b0, 1'b1};

        rst      = 1'b1;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_wr_en", {31'b0, dbg_wr_en}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_hold", {31'b0, cpu_hold}, 32'd0);
        check("rst_addr", dbg_addr, 32'd0);
        check("rst_instr", dbg_instr, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            fill_words(vecs[v].n, vecs[v].w0, vecs[v].w1);
            run_frame(vecs[v].n, vecs[v].cs_mode, vecs[v].cs_val, vecs[v].gap,
                      vecs[v].exp_done, vecs[v].exp_err, $sformatf("vec%0d", v));
        end

        // Strobe lands the cycle after the 4th data byte; input stalls for exactly that cycle.
        pulse_load();
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        check("strobe_en", {31'b0, dbg_wr_en}, 32'd1);
        check("strobe_addr", dbg_addr, BASE);
        check("strobe_data", dbg_instr, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("strobe_drop", {31'b0, dbg_wr_en}, 32'd0);
        check("csum_ready", {31'b0, in_ready}, 32'd1);
        check("strobe_data_hold", dbg_instr, 32'hDEADBEEF);
        x = 8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE;
        send_byte(x, 0);
        check("strobe_done", {31'b0, done}, 32'd1);
        check("strobe_one_write", wa_q.size(), 32'd1);

        // load_req pulsed mid-load with bubbles on in_valid must be ignored.
        fill_words(3, 32'h00100073, 32'h00008067);
        fork
            run_frame(3, 0, 8'h00, 1, 1'b1, 1'b0, "midreq");
            begin
                repeat (9) @(posedge clk);
                #1;
                load_req = 1'b1;
                @(posedge clk);
                #1;
                load_req = 1'b0;
            end
        join

        // Reset after the 6th byte, with load_req in the same cycle: reset wins.
        fill_words(2, 32'h00000013, 32'h00A00093);
        build_frame(2, x);
        pulse_load();
        for (int i = 0; i < 6; i++) send_byte(bq[i], 0);
        rst      = 1'b1;
        load_req = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        load_req = 1'b0;
        check("rst_mid_hold", {31'b0, cpu_hold}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_ready", {31'b0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_idle_busy", {31'b0, busy}, 32'd0);
        check("rst_no_writes", wa_q.size(), 32'd0);
        run_frame(2, 0, 8'h00, 0, 1'b1, 1'b0, "after_rst");

        // Randomized frames; model: writes BASE+4i <- word i for an accepted count, done only
        // when the count fits and the checksum equals the XOR of header and data bytes.
        for (int t = 0; t < 20; t++) begin
            int unsigned n;
            bit          bad;
            bit          ok;
            n   = ($urandom_range(99) < 12) ? MAX_WORDS + 1 + $urandom_range(3) : $urandom_range(6);
            bad = 1'($urandom_range(1));
            ok  = (n <= MAX_WORDS) && !bad;
            fill_words(n, $urandom, $urandom);
            run_frame(n, bad ? 2 : 0, 8'($urandom_range(255, 1)), -1, ok, !ok,
                      $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
